// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern transmitter.
//   - Width constants for the pattern, length and counter fields.
//   - 2-bit state encodings and the FSM state type built on them.
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int PAT_W = 8;   // pattern register width
  localparam int LEN_W = 4;   // length field width on the interface
  localparam int CNT_W = 4;   // repeat and gap counter width
  localparam int BIT_W = 3;   // bit index counter width (indexes 0..7)

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_SHIFT = SHIFT,
    S_GAP   = GAP
  } state_t;

endpackage : seq_pkg

// File: rtl/seq_down_cnt.sv
// -----------------------------------------------------------------------------
// seq_down_cnt
// Loadable down-counter that saturates at zero.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_en        clock enable; low holds the count
//   i_load      load i_load_val (has priority over decrement)
//   i_load_val  value to load
//   i_dec       decrement by one, ignored when the count is already 0
//   o_count     current count
//   o_zero      count == 0
// -----------------------------------------------------------------------------
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
        r_count <= r_count - W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : seq_down_cnt

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter. On an accepted start the low i_len bits of
// i_pattern are sent MSB-first, i_repeat+1 times, with i_gap idle cycles
// between repetitions. o_done pulses for one enabled cycle after the last bit.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     clock enable; low freezes every register
//   i_start      start request, sampled only in IDLE
//   i_pattern    pattern bits
//   i_len        pattern length 1..8 (0 or >8 means 8)
//   i_repeat     extra repetitions
//   i_gap        idle cycles between repetitions
//   o_seq        serial data bit
//   o_seq_valid  o_seq carries a pattern bit
//   o_busy       transmission in progress (SHIFT or GAP)
//   o_done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_pattern_tx
  import seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_repeat,
  input  logic [CNT_W-1:0] i_gap,
  output logic             o_seq,
  output logic             o_seq_valid,
  output logic             o_busy,
  output logic             o_done
);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [BIT_W-1:0] r_len_m1;   // effective length minus one
  logic [CNT_W-1:0] r_gap;
  logic             r_seq;
  logic             r_seq_valid;
  logic             r_busy;
  logic             r_done;

  logic [BIT_W-1:0] w_len_m1_in;
  logic [BIT_W-1:0] w_bit_cnt;
  logic [BIT_W-1:0] w_bit_prev;
  logic             w_bit_zero;
  logic [CNT_W-1:0] w_rep_cnt;
  logic             w_rep_zero;
  logic [CNT_W-1:0] w_gap_cnt;
  logic             w_gap_zero;

  logic             w_bit_load;
  logic [BIT_W-1:0] w_bit_load_val;
  logic             w_bit_dec;
  logic             w_rep_load;
  logic             w_rep_dec;
  logic             w_gap_load;
  logic             w_gap_dec;

  // Repeat and gap counters are only consulted through their zero flags.
  logic             w_unused_cnts;
  assign w_unused_cnts = ^{w_rep_cnt, w_gap_cnt};

  // Lengths 1..8 map to index len-1 using the low 3 bits (8 wraps to 7);
  // 0 and anything above 8 select the full 8-bit pattern.
  always_comb begin
    if ((i_len == '0) || (i_len > LEN_W'(8))) begin
      w_len_m1_in = 3'd7;
    end else begin
      w_len_m1_in = i_len[BIT_W-1:0] - 3'd1;
    end
  end

  assign w_bit_prev = w_bit_cnt - 3'd1;

  // The bit counter holds the index of the bit currently on o_seq.
  // The gap counter is loaded with gap-1 so that GAP lasts exactly gap cycles.
  always_comb begin
    w_bit_load     = 1'b0;
    w_bit_load_val = r_len_m1;
    w_bit_dec      = 1'b0;
    w_rep_load     = 1'b0;
    w_rep_dec      = 1'b0;
    w_gap_load     = 1'b0;
    w_gap_dec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_bit_load     = 1'b1;
          w_bit_load_val = w_len_m1_in;
          w_rep_load     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!w_bit_zero) begin
          w_bit_dec = 1'b1;
        end else if (!w_rep_zero) begin
          w_rep_dec = 1'b1;
          if (r_gap == '0) begin
            w_bit_load = 1'b1;
          end else begin
            w_gap_load = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_gap_zero) begin
          w_bit_load = 1'b1;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  seq_down_cnt #(.W(BIT_W)) u_bit_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_enable),
    .i_load     (w_bit_load),
    .i_load_val (w_bit_load_val),
    .i_dec      (w_bit_dec),
    .o_count    (w_bit_cnt),
    .o_zero     (w_bit_zero)
  );

  seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_enable),
    .i_load     (w_rep_load),
    .i_load_val (i_repeat),
    .i_dec      (w_rep_dec),
    .o_count    (w_rep_cnt),
    .o_zero     (w_rep_zero)
  );

  seq_down_cnt #(.W(CNT_W)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_enable),
    .i_load     (w_gap_load),
    .i_load_val (r_gap - CNT_W'(1)),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt),
    .o_zero     (w_gap_zero)
  );

  // State and all outputs are registered together, so each output reflects
  // the state being entered on this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_len_m1    <= '0;
      r_gap       <= '0;
      r_seq       <= 1'b0;
      r_seq_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        S_IDLE: begin
          r_done      <= 1'b0;
          r_seq       <= 1'b0;
          r_seq_valid <= 1'b0;
          r_busy      <= 1'b0;
          if (i_start) begin
            r_pat       <= i_pattern;
            r_len_m1    <= w_len_m1_in;
            r_gap       <= i_gap;
            r_state     <= S_SHIFT;
            r_seq       <= i_pattern[w_len_m1_in];
            r_seq_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_done <= 1'b0;
          if (!w_bit_zero) begin
            r_seq       <= r_pat[w_bit_prev];
            r_seq_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else if (!w_rep_zero) begin
            r_busy <= 1'b1;
            if (r_gap == '0) begin
              // Back-to-back repetition: restart at the top bit immediately.
              r_seq       <= r_pat[r_len_m1];
              r_seq_valid <= 1'b1;
            end else begin
              r_state     <= S_GAP;
              r_seq       <= 1'b0;
              r_seq_valid <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_seq       <= 1'b0;
            r_seq_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        S_GAP: begin
          r_done <= 1'b0;
          r_busy <= 1'b1;
          if (w_gap_zero) begin
            r_state     <= S_SHIFT;
            r_seq       <= r_pat[r_len_m1];
            r_seq_valid <= 1'b1;
          end else begin
            r_seq       <= 1'b0;
            r_seq_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_seq       <= 1'b0;
          r_seq_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign o_seq       = r_seq;
  assign o_seq_valid = r_seq_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule : seq_pattern_tx

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
// Self-checking bench for seq_pattern_tx: a table of whole-transaction
// vectors, hand-written multi-cycle sequences (enable freeze, back-to-back
// start, reset abort) and randomized transactions compared cycle by cycle
// against a stream model built from the transmission rules.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_start;
  logic [7:0] i_pattern;
  logic [3:0] i_len;
  logic [3:0] i_repeat;
  logic [3:0] i_gap;
  logic       o_seq;
  logic       o_seq_valid;
  logic       o_busy;
  logic       o_done;

  int checks   = 0;
  int failures = 0;

  // Expected {seq, valid, busy, done} for each cycle after the start edge.
  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [3:0]  gap;
    logic [31:0] bits;
    int          nbits;
    int          done_cyc;
  } vec_t;

  vec_t tbl[8];

  seq_pattern_tx dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_start     (i_start),
    .i_pattern   (i_pattern),
    .i_len       (i_len),
    .i_repeat    (i_repeat),
    .i_gap       (i_gap),
    .o_seq       (o_seq),
    .o_seq_valid (o_seq_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic [3:0] exp);
    logic [3:0] act;
    act = {o_seq, o_seq_valid, o_busy, o_done};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got seq/valid/busy/done=%b exp=%b", nm, act, exp);
    end
  endtask

  // Stream model: every repetition sends bits len-1..0, separated by gap idle
  // busy cycles, followed by a single done cycle.
  task automatic build_exp(input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] rp, input logic [3:0] g);
    int n;
    exp_q.delete();
    n = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    for (int r = 0; r <= int'(rp); r++) begin
      for (int b = n - 1; b >= 0; b--) begin
        exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
      end
      if (r < int'(rp)) begin
        for (int k = 0; k < int'(g); k++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
  endtask

  // Start one transaction and compare every cycle with the model. When
  // scramble is set, the parameter inputs and i_start are randomized while
  // busy; start_at pulses i_start on that cycle index.
  task automatic run_tx(input string nm, input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] rp, input logic [3:0] g,
                        input bit scramble, input int start_at);
    build_exp(p, l, rp, g);
    i_pattern = p;
    i_len     = l;
    i_repeat  = rp;
    i_gap     = g;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_outs(nm, exp_q[k]);
      if (k != exp_q.size() - 1) begin
        if (scramble) begin
          i_pattern = 8'($urandom);
          i_len     = 4'($urandom);
          i_repeat  = 4'($urandom);
          i_gap     = 4'($urandom);
          i_start   = 1'($urandom);
        end
        if (k == start_at) i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      tick();
      i_start = 1'b0;
    end
    check_outs({nm, "_idle"}, 4'b0000);
  endtask

  initial begin
    logic [31:0] acc;
    int          nv;
    int          cyc;
    bit          got_done;

    tbl[0] = '{8'h05, 4'd3,  4'd0, 4'd0, 32'b101,              3,  4};
    tbl[1] = '{8'h05, 4'd3,  4'd2, 4'd0, 32'b101101101,        9,  10};
    tbl[2] = '{8'h05, 4'd3,  4'd1, 4'd2, 32'b101101,           6,  9};
    tbl[3] = '{8'hA5, 4'd0,  4'd0, 4'd0, 32'hA5,               8,  9};
    tbl[4] = '{8'hA5, 4'd12, 4'd0, 4'd0, 32'hA5,               8,  9};
    tbl[5] = '{8'hFF, 4'd1,  4'd3, 4'd1, 32'b1111,             4,  8};
    tbl[6] = '{8'h36, 4'd5,  4'd0, 4'd0, 32'b10110,            5,  6};
    tbl[7] = '{8'h80, 4'd8,  4'd1, 4'd0, 32'h8080,             16, 17};

    // Reset state
    i_rst_n   = 1'b0;
    i_enable  = 1'b1;
    i_start   = 1'b0;
    i_pattern = 8'h00;
    i_len     = 4'd0;
    i_repeat  = 4'd0;
    i_gap     = 4'd0;
    #1;
    check_outs("reset_state", 4'b0000);
    i_start = 1'b1;
    tick();
    check_outs("reset_ignores_start", 4'b0000);
    i_start = 1'b0;
    #2 i_rst_n = 1'b1;
    tick();
    check_outs("idle_after_reset", 4'b0000);

    // Table-driven whole transactions
    for (int t = 0; t < 8; t++) begin
      i_pattern = tbl[t].pat;
      i_len     = tbl[t].len;
      i_repeat  = tbl[t].rep;
      i_gap     = tbl[t].gap;
      i_start   = 1'b1;
      tick();
      i_start  = 1'b0;
      acc      = '0;
      nv       = 0;
      cyc      = 1;
      got_done = 1'b0;
      while (!got_done && cyc < 300) begin
        if (o_done) begin
          got_done = 1'b1;
        end else begin
          if (o_seq_valid) begin
            acc = {acc[30:0], o_seq};
            nv++;
          end
          tick();
          cyc++;
        end
      end
      check_val($sformatf("tbl%0d_done_seen", t), 32'(got_done), 32'd1);
      check_val($sformatf("tbl%0d_done_cycle", t), 32'(cyc), 32'(tbl[t].done_cyc));
      check_val($sformatf("tbl%0d_nbits", t), 32'(nv), 32'(tbl[t].nbits));
      check_val($sformatf("tbl%0d_bits", t), acc, tbl[t].bits);
      check_val($sformatf("tbl%0d_busy_at_done", t), 32'(o_busy), 32'd0);
      tick();
      check_outs($sformatf("tbl%0d_idle", t), 4'b0000);
    end

    // Cycle-exact runs of the headline cases, including the gap shape
    run_tx("single_101", 8'h05, 4'd3, 4'd0, 4'd0, 1'b0, -1);
    run_tx("rep2_nogap", 8'h05, 4'd3, 4'd2, 4'd0, 1'b0, -1);
    run_tx("rep1_gap2",  8'h05, 4'd3, 4'd1, 4'd2, 1'b0, -1);
    run_tx("a5_start_ignored", 8'hA5, 4'd0, 4'd0, 4'd0, 1'b0, 3);

    // Enable held low during the second bit, then o_done held by enable
    build_exp(8'hA5, 4'd0, 4'd0, 4'd0);
    i_pattern = 8'hA5;
    i_len     = 4'd0;
    i_repeat  = 4'd0;
    i_gap     = 4'd0;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    check_outs("frz_bit1", exp_q[0]);
    tick();
    check_outs("frz_bit2", exp_q[1]);
    i_enable = 1'b0;
    i_start  = 1'b1;
    repeat (3) begin
      tick();
      check_outs("frz_hold", exp_q[1]);
    end
    i_enable = 1'b1;
    i_start  = 1'b0;
    for (int k = 2; k < exp_q.size(); k++) begin
      tick();
      check_outs("frz_resume", exp_q[k]);
    end
    i_enable = 1'b0;
    i_start  = 1'b1;
    repeat (2) begin
      tick();
      check_outs("done_held", 4'b0001);
    end
    // Start accepted in the o_done cycle
    i_enable  = 1'b1;
    i_pattern = 8'h05;
    i_len     = 4'd3;
    tick();
    i_start   = 1'b0;
    i_pattern = 8'h00;
    i_len     = 4'd7;
    check_outs("b2b_bit1", 4'b1110);
    tick();
    check_outs("b2b_bit2", 4'b0110);
    tick();
    check_outs("b2b_bit3", 4'b1110);
    tick();
    check_outs("b2b_done", 4'b0001);
    tick();
    check_outs("b2b_idle", 4'b0000);

    // Reset asserted during bit 5 aborts without o_done
    build_exp(8'hA5, 4'd0, 4'd0, 4'd0);
    i_pattern = 8'hA5;
    i_len     = 4'd0;
    i_start   = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_outs("rst_pre", exp_q[k]);
      tick();
    end
    check_outs("rst_bit5", exp_q[4]);
    #2 i_rst_n = 1'b0;
    #1;
    check_outs("rst_async", 4'b0000);
    i_start = 1'b1;
    repeat (3) begin
      tick();
      check_outs("rst_hold", 4'b0000);
    end
    i_start = 1'b0;
    #2 i_rst_n = 1'b1;
    #1;
    check_outs("rst_release", 4'b0000);
    tick();
    check_outs("rst_no_done", 4'b0000);
    run_tx("post_rst", 8'h05, 4'd3, 4'd0, 4'd0, 1'b0, -1);

    // Randomized transactions with inputs scrambled while busy
    for (int n = 0; n < 24; n++) begin
      run_tx($sformatf("rand%0d", n), 8'($urandom), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_pattern_tx
